mem_ctrl_unit: RTL
==================

# mem_ctrl_unit

Control sequencer for the Mini-SRC datapath covering the memory-reference subset (ld, ldi, st) plus halt. The testbench currently generates the datapath's T0–T7 control strobes by hand. This block generates them instead: it reads the instruction register and steps its own state register. It sits beside `Datapath` and drives that module's existing control inputs by the same names.

## Interface
Parameters:
- `OPC_LD`, default 5'b00000, ld opcode (IR[31:27]).
- `OPC_LDI`, default 5'b00001, ldi opcode.
- `OPC_ST`, default 5'b00010, st opcode.
- `OPC_HALT`, default 5'b11011, halt opcode.

Ports:
- `clock`, in, 1, single clock; all state changes on the rising edge.
- `clear`, in, 1, asynchronous, active-low reset.
- `IR`, in, 32, instruction register contents from the datapath.
- `Stop`, in, 1, request to pause at the next instruction boundary.
- `PCout`, `MDRout`, `Zlowout`, `BAout`, `Cout`, out, 1 each, bus-source selects.
- `PCin`, `MARin`, `MDRin`, `IRin`, `Yin`, `Zlowin`, out, 1 each, register loads.
- `IncPC`, `Read`, `Write`, out, 1 each, PC increment and memory strobes.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, out, 1 each, register-file select and enable.
- `Run`, out, 1, high unless halted.

## Operation
- States: `RST`, `T0`–`T7`, `HALT`. Encoding is free.
- Outputs are a Moore decode of the state register and IR[31:27]. Every strobe not listed for a state is 0.
- Strobes per state:
  - `RST`: all strobes 0.
  - T0: PCout, MARin, IncPC, PCin.
  - T1: Read, MDRin.
  - T2: MDRout, IRin.
  - T3 (ld/ldi/st): Grb, BAout, Yin.
  - T4 (ld/ldi/st): Cout, Zlowin.
  - T5, ld/st: Zlowout, MARin.
  - T5, ldi: Zlowout, Gra, Rin.
  - T6, ld: Read, MDRin.
  - T6, st: Gra, Rout, MDRin; Read stays 0, so MDR loads from the bus.
  - T7, ld: MDRout, Gra, Rin.
  - T7, st: Write.
- Grc is reserved and always 0.
- Transitions:
  - `RST` -> T0 on the first edge after `clear` deasserts.
  - T0 -> T1 -> T2 -> T3.
  - At T3, IR[31:27] is decoded. ld/ldi/st continue to T4. Halt goes to `HALT`. Any other opcode returns to T0 as a no-op with no strobes in T3.
  - T4 -> T5. From T5, ldi returns to T0; ld/st go to T6 -> T7 -> T0.
  - `HALT` holds until `clear` is asserted.
- `Stop` is sampled only on the edge that would enter T0, from `RST`, from the last state of an instruction, or from the T3 no-op return. While `Stop`=1 the block stays in its current state with all strobes 0. Sampling resumes when `Stop` returns to 0.

## Timing
- Reset: `clear`=0 forces `RST` immediately, without waiting for a clock edge. All strobes are 0 and `Run`=1 during reset.
- Asserting `clear` mid-instruction aborts it at once. Strobes drop within the same delta and no partial Write completes after reset asserts.
- Each state lasts exactly one clock.
- Instruction lengths: ld = 8 cycles (T0–T7), st = 8 cycles, ldi = 6 cycles (T0–T5), unsupported opcode = 4 cycles (T0–T3).
- IR is latched at the end of T2. The opcode is therefore decoded no earlier than T3; T0–T2 must not depend on IR.
- `Run` falls on the edge that enters `HALT` and stays 0 until `clear`.
- Read and Write are never high in the same cycle. Write is high for exactly one cycle per st.

## Test plan
- Reset and ld:
  - Stimulus: `clear`=0 for 2 cycles, then 1. IR = 0x00900015 (ld R1, 0x15(R2)) once IRin fires, with R2 = 20.
  - Response: strobes match T0–T7 above in exactly 8 cycles. R1 receives memory[0x29]. The next cycle is T0.
- ldi:
  - Stimulus: IR = 0x08900005 (ldi R1, 5(R2)), R2 = 20.
  - Response: Gra·Rin·Zlowout in the 6th cycle. R1 = 25. Read is high only in T1.
- st:
  - Stimulus: IR = 0x10900087 (st 0x87(R2), R1), R1 = 0xA5, R2 = 20.
  - Response: Write high only in T7. memory[0x9B] = 0xA5.
- Unsupported opcode and halt:
  - Stimulus: IR = 0x18000000, then IR = 0xD8000000.
  - Response: the first returns to T0 after T3 with no T3 strobes. The second enters `HALT`, `Run`=0, and all strobes stay 0 for 10+ cycles.
- Stop:
  - Stimulus: `Stop`=1 asserted during T5 of an ld.
  - Response: T6 and T7 complete, then the block holds with zero strobes. T0 begins on the first edge after `Stop`=0.
- Reset mid-st:
  - Stimulus: `clear`=0 during T6 of a st.
  - Response: all strobes drop immediately, Write is never asserted, and memory is unchanged.

Source files
------------

// File: rtl/mem_ctrl_unit.sv
// mem_ctrl_unit: Mini-SRC control sequencer for ld, ldi, st and halt.
// Steps RST/T0-T7/HALT from IR[31:27] and decodes the datapath control strobes.
module mem_ctrl_unit #(
   parameter logic [4:0] OPC_LD   = 5'b00000,
   parameter logic [4:0] OPC_LDI  = 5'b00001,
   parameter logic [4:0] OPC_ST   = 5'b00010,
   parameter logic [4:0] OPC_HALT = 5'b11011
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        Stop,
   output logic        PCout,
   output logic        MDRout,
   output logic        Zlowout,
   output logic        BAout,
   output logic        Cout,
   output logic        PCin,
   output logic        MARin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        Zlowin,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        Run
);
   typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
   state_t state;
   logic hold, ld, ldi, st, mem, halt, done, unused_bits;
   logic [9:0] t;
   assign ld   = IR[31:27] == OPC_LD;
   assign ldi  = IR[31:27] == OPC_LDI;
   assign st   = IR[31:27] == OPC_ST;
   assign halt = IR[31:27] == OPC_HALT;
   assign mem  = ld | ldi | st;
   // Edges that would enter T0; only these sample Stop.
   assign done = state == RST || state == T7 || (state == T5 && ldi) || (state == T3 && !mem && !halt);
   always_ff @(posedge clock or negedge clear)
      if (!clear) begin
         state <= RST;
         hold  <= 1'b0;
      end else if (done) begin
         hold <= Stop;
         if (!Stop) state <= T0;
      end else if (state == T3) state <= halt ? HALT : T4;
      else if (state != HALT) state <= state_t'(state + 4'd1);
   // One-hot view of the state; a held state decodes to no strobes.
   assign t = hold ? 10'd0 : 10'd1 << state;
   assign PCout   = t[T0];
   assign IncPC   = t[T0];
   assign PCin    = t[T0];
   assign MARin   = t[T0] | t[T5] & (ld | st);
   assign Read    = t[T1] | t[T6] & ld;
   assign MDRin   = t[T1] | t[T6] & (ld | st);
   assign MDRout  = t[T2] | t[T7] & ld;
   assign IRin    = t[T2];
   assign Grb     = t[T3] & mem;
   assign BAout   = t[T3] & mem;
   assign Yin     = t[T3] & mem;
   assign Cout    = t[T4] & mem;
   assign Zlowin  = t[T4] & mem;
   assign Zlowout = t[T5] & mem;
   assign Gra     = t[T5] & ldi | t[T6] & st | t[T7] & ld;
   assign Rin     = t[T5] & ldi | t[T7] & ld;
   assign Rout    = t[T6] & st;
   assign Write   = t[T7] & st;
   assign Grc     = 1'b0;
   assign Run     = state != HALT;
   assign unused_bits = ^{IR[26:0], t[RST], t[HALT]};
endmodule
